clock_mode_ctrl: RTL and testbench

Parametrised successor to the digital-clock mode FSM. It sits between the debounced push-button and switch inputs and the time, stopwatch, alarm and date datapaths.
- Classifies `mode` presses as short or long against a parametrised threshold.
- Sequences the TIME, STW, ALM and DATE screens, using one generic SET state per function with a field index instead of per-field states.
- Supports `NUM_ALARMS` independent alarms.
- Abandons a set session automatically after an inactivity timeout.

---
 rtl/clock_mode_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// clock_mode_ctrl
//
// Mode sequencer for the digital clock. Sits between the debounced buttons and
// the time / stopwatch / alarm / date datapaths. It classifies mode presses
// as short or long, walks the TIME -> STW -> ALM -> DATE screens, runs one
// generic SET state per function with a field index, keeps NUM_ALARMS armed
// flags and abandons an idle set session after TIMEOUT_CYCLES.
//
// Optional feature macro: AUTO_REPEAT_EN
//   defined   : set_enable pulses on the switch rising edge and auto-repeats
//               while switch is held (REPEAT_DELAY, then every REPEAT_PERIOD)
//   undefined : set_enable follows the switch level inside SET states
//
// Ports
//   clk                    in  system clock
//   rst_n                  in  asynchronous active-low reset
//   mode                   in  debounced mode button (level)
//   display_mode           in  one-cycle pulse: alt display / lap / alarm select
//   switch                 in  debounced set/start button (level)
//   state                  out current state encoding (4 bits)
//   set_enable             out increment the selected field
//   set_sel                out one-hot field select (3 bits)
//   stopwatch_count_enable out stopwatch runs
//   data_load_enable       out commit edit register / freeze lap display
//   reg_load_enable        out copy live value into the edit register
//   alarm_enable           out per-alarm armed flags (registered)
//   alm_sel                out selected alarm channel (registered)
//   timeout_exit           out one-cycle pulse when a SET session is abandoned
// -----------------------------------------------------------------------------
module clock_mode_ctrl #(
  parameter int LONG_CYCLES    = 3,
  parameter int NUM_ALARMS     = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int REPEAT_DELAY   = 8,
  parameter int REPEAT_PERIOD  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  display_mode,
  input  logic                  switch,
  output logic [3:0]            state,
  output logic                  set_enable,
  output logic [2:0]            set_sel,
  output logic                  stopwatch_count_enable,
  output logic                  data_load_enable,
  output logic                  reg_load_enable,
  output logic [NUM_ALARMS-1:0] alarm_enable,
  output logic [1:0]            alm_sel,
  output logic                  timeout_exit
);

  typedef enum logic [3:0] {
    TIME_DISP  = 4'd0,
    TIME_DISP1 = 4'd1,
    TIME_SET   = 4'd2,
    STW_DISP   = 4'd3,
    STW_COUNT  = 4'd4,
    STW_LAP    = 4'd5,
    ALM_DISP   = 4'd6,
    ALM_SET    = 4'd7,
    DATE_DISP  = 4'd8,
    DATE_DISP1 = 4'd9,
    DATE_SET   = 4'd10
  } state_t;

  // Press counter only needs to reach LONG_CYCLES (saturation value).
  localparam int CNT_W = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LONG = CNT_W'(LONG_CYCLES - 1);

  // Idle counter holds 0..TIMEOUT_CYCLES-1; the last value triggers the exit.
  localparam int IDLE_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST =
    IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] ALM_LAST = 2'(NUM_ALARMS - 1);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    mode_q_reg;
  logic                    switch_q_reg;
  logic [1:0]              field_reg, field_next;
  logic [IDLE_W-1:0]       idle_cnt_reg;
  logic [NUM_ALARMS-1:0]   alarm_enable_reg;
  logic [1:0]              alm_sel_reg;

  logic                    long_press;
  logic                    short_press;
  logic                    switch_rise;
  logic                    idle_hit;
  logic                    in_set;
  logic                    rep_pulse;
  logic                    alm_toggle;
  logic                    alm_step;
  logic [NUM_ALARMS-1:0]   alarm_toggle;
  logic [1:0]              field_last;
  logic [2:0]              sel_decode;

  function automatic logic is_set_state(input state_t s);
    return (s == TIME_SET) || (s == ALM_SET) || (s == DATE_SET);
  endfunction

  function automatic state_t parent_of(input state_t s);
    case (s)
      ALM_SET:  return ALM_DISP;
      DATE_SET: return DATE_DISP;
      default:  return TIME_DISP;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Press classification
  // long fires once per hold on the LONG_CYCLES-th high cycle; a release only
  // counts as short if the counter never saturated.
  // ---------------------------------------------------------------------------
  assign long_press  = mode & (cnt_reg == CNT_LONG);
  assign short_press = ~mode & mode_q_reg & (cnt_reg < CNT_MAX);
  assign switch_rise = switch & ~switch_q_reg;

  assign in_set   = is_set_state(state_reg);
  assign idle_hit = (TIMEOUT_CYCLES > 0) && (idle_cnt_reg == IDLE_LAST);

  // ---------------------------------------------------------------------------
  // Field handling: ALM has two fields, TIME and DATE have three.
  // Index 0 is always the middle field (min / month) so entry selects 010.
  // ---------------------------------------------------------------------------
  assign field_last = (state_reg == ALM_SET) ? 2'd1 : 2'd2;

  always_comb begin
    sel_decode = 3'b000;
    if (state_reg == ALM_SET) begin
      case (field_reg)
        2'd0:    sel_decode = 3'b010;
        2'd1:    sel_decode = 3'b100;
        default: sel_decode = 3'b000;
      endcase
    end else begin
      case (field_reg)
        2'd0:    sel_decode = 3'b010;
        2'd1:    sel_decode = 3'b001;
        2'd2:    sel_decode = 3'b100;
        default: sel_decode = 3'b000;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // set_enable source
  // ---------------------------------------------------------------------------
`ifdef AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX < 2) ? 1 : $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_reg;

  // Down-counter: loaded with DELAY-1 on the rising edge, then reloaded with
  // PERIOD-1 each time it reaches zero while switch stays high.
  assign rep_pulse = switch_rise | (switch & switch_q_reg & (rep_cnt_reg == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_reg <= '0;
    end else if (!switch) begin
      rep_cnt_reg <= '0;
    end else if (switch_rise) begin
      rep_cnt_reg <= REP_W'(REPEAT_DELAY - 1);
    end else if (rep_cnt_reg == '0) begin
      rep_cnt_reg <= REP_W'(REPEAT_PERIOD - 1);
    end else begin
      rep_cnt_reg <= rep_cnt_reg - REP_W'(1);
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
  assign rep_pulse         = switch;
`endif

  // ---------------------------------------------------------------------------
  // Alarm toggle decode: one enable per channel
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_alarm
      assign alarm_toggle[gi] = alm_toggle & (alm_sel_reg == 2'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state and Mealy outputs. Priority: long > short > switch > display.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next             = state_reg;
    field_next             = field_reg;
    set_enable             = 1'b0;
    set_sel                = 3'b000;
    stopwatch_count_enable = 1'b0;
    data_load_enable       = 1'b0;
    reg_load_enable        = 1'b0;
    timeout_exit           = 1'b0;
    alm_toggle             = 1'b0;
    alm_step               = 1'b0;

    case (state_reg)
      TIME_DISP: begin
        if (long_press) begin
          state_next      = TIME_SET;
          reg_load_enable = 1'b1;
        end else if (short_press) begin
          state_next = STW_DISP;
        end else if (display_mode) begin
          state_next = TIME_DISP1;
        end
      end

      TIME_DISP1: begin
        if (display_mode) state_next = TIME_DISP;
      end

      TIME_SET, ALM_SET, DATE_SET: begin
        set_sel = sel_decode;
        if (long_press) begin
          state_next       = parent_of(state_reg);
          data_load_enable = 1'b1;
        end else if (short_press) begin
          field_next = (field_reg == field_last) ? 2'd0 : field_reg + 2'd1;
        end else if (switch) begin
          set_enable = rep_pulse;
        end else if (idle_hit) begin
          // Edit is discarded: no data_load_enable on this exit.
          state_next   = parent_of(state_reg);
          timeout_exit = 1'b1;
        end
      end

      STW_DISP: begin
        if (short_press) begin
          state_next = ALM_DISP;
        end else if (switch) begin
          state_next             = STW_COUNT;
          stopwatch_count_enable = 1'b1;
        end
      end

      STW_COUNT: begin
        stopwatch_count_enable = 1'b1;
        if (switch) begin
          state_next = STW_DISP;
        end else if (display_mode) begin
          state_next       = STW_LAP;
          data_load_enable = 1'b1;
        end
      end

      STW_LAP: begin
        stopwatch_count_enable = 1'b1;
        data_load_enable       = 1'b1;
        if (switch) begin
          state_next = STW_DISP;
        end else if (display_mode) begin
          state_next = STW_COUNT;
        end
      end

      ALM_DISP: begin
        if (long_press) begin
          state_next      = ALM_SET;
          reg_load_enable = 1'b1;
        end else if (short_press) begin
          state_next = DATE_DISP;
        end else if (switch_rise) begin
          alm_toggle = 1'b1;
        end else if (display_mode) begin
          alm_step = 1'b1;
        end
      end

      DATE_DISP: begin
        if (long_press) begin
          state_next      = DATE_SET;
          reg_load_enable = 1'b1;
        end else if (short_press) begin
          state_next = TIME_DISP;
        end else if (display_mode) begin
          state_next = DATE_DISP1;
        end
      end

      DATE_DISP1: begin
        if (display_mode) state_next = DATE_DISP;
      end

      default: state_next = TIME_DISP;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= TIME_DISP;
      cnt_reg          <= '0;
      mode_q_reg       <= 1'b0;
      switch_q_reg     <= 1'b0;
      field_reg        <= 2'd0;
      idle_cnt_reg     <= '0;
      alarm_enable_reg <= '0;
      alm_sel_reg      <= 2'd0;
    end else begin
      state_reg    <= state_next;
      mode_q_reg   <= mode;
      switch_q_reg <= switch;

      if (!mode) begin
        cnt_reg <= '0;
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end

      // Outside SET states both are held at zero, so every entry starts fresh.
      if (!in_set) begin
        field_reg    <= 2'd0;
        idle_cnt_reg <= '0;
      end else begin
        field_reg <= field_next;
        if (long_press || short_press || switch) begin
          idle_cnt_reg <= '0;
        end else if (!idle_hit) begin
          idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
        end
      end

      alarm_enable_reg <= alarm_enable_reg ^ alarm_toggle;
      if (alm_step) begin
        alm_sel_reg <= (alm_sel_reg == ALM_LAST) ? 2'd0 : alm_sel_reg + 2'd1;
      end
    end
  end

  assign state        = state_reg;
  assign alarm_enable = alarm_enable_reg;
  assign alm_sel      = alm_sel_reg;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_mode_ctrl
//
// Directed bench for clock_mode_ctrl (LONG_CYCLES=3, NUM_ALARMS=2,
// TIMEOUT_CYCLES=20, REPEAT_DELAY=8, REPEAT_PERIOD=4). The stimulus process
// drives inputs just after each rising edge and queues the hand-computed
// output vector expected for that cycle; a monitor samples on the falling
// edge and compares against the queue head.
// -----------------------------------------------------------------------------
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic       display_mode;
  logic       switch;
  logic [3:0] state;
  logic       set_enable;
  logic [2:0] set_sel;
  logic       stopwatch_count_enable;
  logic       data_load_enable;
  logic       reg_load_enable;
  logic [1:0] alarm_enable;
  logic [1:0] alm_sel;
  logic       timeout_exit;

  clock_mode_ctrl #(
    .LONG_CYCLES   (3),
    .NUM_ALARMS    (2),
    .TIMEOUT_CYCLES(20),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .mode                  (mode),
    .display_mode          (display_mode),
    .switch                (switch),
    .state                 (state),
    .set_enable            (set_enable),
    .set_sel               (set_sel),
    .stopwatch_count_enable(stopwatch_count_enable),
    .data_load_enable      (data_load_enable),
    .reg_load_enable       (reg_load_enable),
    .alarm_enable          (alarm_enable),
    .alm_sel               (alm_sel),
    .timeout_exit          (timeout_exit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       tag;
    logic [15:0] vec;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Bench-side copies of the registered alarm outputs, updated by hand.
  logic [1:0] ae_m = 2'b00;
  logic [1:0] as_m = 2'b00;

  logic [15:0] act_vec;
  assign act_vec = {state, set_enable, set_sel, stopwatch_count_enable,
                    data_load_enable, reg_load_enable, alarm_enable, alm_sel,
                    timeout_exit};

  // Monitor: vector layout st[15:12] se sel[2:0] cen ld rl ae[1:0] as[1:0] to
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      n_checks++;
      if (mon_e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: sample for cycle %0d missed (now %0d)", mon_e.tag, mon_e.cyc, cyc);
      end else if (act_vec !== mon_e.vec) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %b required %b", mon_e.tag, cyc, act_vec, mon_e.vec);
      end else begin
        $display("ok   %s cycle %0d: %b", mon_e.tag, cyc, act_vec);
      end
    end
  end

  task automatic ex(input string tag, input logic [3:0] st, input logic [2:0] sel,
                    input logic se, input logic cen, input logic ld, input logic rl,
                    input logic to);
    exp_t e;
    e.cyc = cyc;
    e.tag = tag;
    e.vec = {st, se, sel, cen, ld, rl, ae_m, as_m, to};
    sbq.push_back(e);
  endtask

  task automatic drive(input logic m, input logic dm, input logic sw);
    @(posedge clk);
    #1;
    mode         = m;
    display_mode = dm;
    switch       = sw;
  endtask

  // One high cycle then release: a short press acted on in the release cycle.
  task automatic quick_short();
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic se_exp;
    rst_n = 1'b0; mode = 1'b0; display_mode = 1'b0; switch = 1'b0;

    // Reset state
    @(posedge clk); #1;
    ex("reset", 4'd0, 3'b000, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ex("post_reset", 4'd0, 3'b000, 0, 0, 0, 0, 0);

    // Short press TIME_DISP -> STW_DISP
    drive(1, 0, 0); ex("short_hi1", 4'd0, 3'b000, 0, 0, 0, 0, 0);
    drive(1, 0, 0); ex("short_hi2", 4'd0, 3'b000, 0, 0, 0, 0, 0);
    drive(0, 0, 0); ex("short_rel", 4'd0, 3'b000, 0, 0, 0, 0, 0);
    drive(0, 0, 0); ex("stw_disp", 4'd3, 3'b000, 0, 0, 0, 0, 0);

    // Stopwatch sequence
    drive(0, 0, 1); ex("stw_start", 4'd3, 3'b000, 0, 1, 0, 0, 0);
    drive(0, 0, 0); ex("stw_count", 4'd4, 3'b000, 0, 1, 0, 0, 0);
    drive(1, 0, 0); ex("stw_cnt_mode", 4'd4, 3'b000, 0, 1, 0, 0, 0);
    drive(0, 0, 0); ex("stw_cnt_norel", 4'd4, 3'b000, 0, 1, 0, 0, 0);
    drive(0, 1, 0); ex("stw_lap_go", 4'd4, 3'b000, 0, 1, 1, 0, 0);
    drive(0, 0, 0); ex("stw_lap", 4'd5, 3'b000, 0, 1, 1, 0, 0);
    drive(0, 1, 0); ex("stw_lap_back", 4'd5, 3'b000, 0, 1, 1, 0, 0);
    drive(0, 0, 0); ex("stw_count2", 4'd4, 3'b000, 0, 1, 0, 0, 0);
    drive(0, 0, 1); ex("stw_stop", 4'd4, 3'b000, 0, 1, 0, 0, 0);
    drive(0, 0, 0); ex("stw_stopped", 4'd3, 3'b000, 0, 0, 0, 0, 0);

    // STW_DISP -> ALM_DISP
    quick_short();
    drive(0, 0, 0); ex("alm_disp", 4'd6, 3'b000, 0, 0, 0, 0, 0);

    // Alarm select walks 0 -> 1 -> 0 -> 1
    drive(0, 1, 0); ex("alm_sel_step", 4'd6, 3'b000, 0, 0, 0, 0, 0);
    as_m = 2'd1;
    drive(0, 0, 0); ex("alm_sel_1", 4'd6, 3'b000, 0, 0, 0, 0, 0);
    drive(0, 1, 0);
    as_m = 2'd0;
    drive(0, 0, 0); ex("alm_sel_wrap", 4'd6, 3'b000, 0, 0, 0, 0, 0);
    drive(0, 1, 0);
    as_m = 2'd1;
    drive(0, 0, 0); ex("alm_sel_1b", 4'd6, 3'b000, 0, 0, 0, 0, 0);

    // Switch rising edge arms alarm 1; holding does not toggle again
    drive(0, 0, 1); ex("alm_arm_edge", 4'd6, 3'b000, 0, 0, 0, 0, 0);
    ae_m = 2'b10;
    drive(0, 0, 1); ex("alm_armed", 4'd6, 3'b000, 0, 0, 0, 0, 0);
    drive(0, 0, 0); ex("alm_armed_hold", 4'd6, 3'b000, 0, 0, 0, 0, 0);

    // ALM_DISP -> DATE_DISP -> TIME_DISP
    quick_short();
    drive(0, 0, 0); ex("date_disp", 4'd8, 3'b000, 0, 0, 0, 0, 0);
    quick_short();
    drive(0, 0, 0); ex("time_disp", 4'd0, 3'b000, 0, 0, 0, 0, 0);

    // Long press: 10 high cycles, fires once on the 3rd
    drive(1, 0, 0); ex("long_hi1", 4'd0, 3'b000, 0, 0, 0, 0, 0);
    drive(1, 0, 0); ex("long_hi2", 4'd0, 3'b000, 0, 0, 0, 0, 0);
    drive(1, 0, 0); ex("long_fire", 4'd0, 3'b000, 0, 0, 0, 1, 0);
    for (int i = 4; i <= 10; i++) begin
      drive(1, 0, 0); ex("long_hold", 4'd2, 3'b010, 0, 0, 0, 0, 0);
    end
    drive(0, 0, 0); ex("long_rel", 4'd2, 3'b010, 0, 0, 0, 0, 0);
    drive(0, 0, 0); ex("long_no_short", 4'd2, 3'b010, 0, 0, 0, 0, 0);

    // TIME_SET: switch level increments, short presses walk the fields
    drive(0, 0, 1); ex("tset_inc", 4'd2, 3'b010, 1, 0, 0, 0, 0);
    drive(0, 0, 0); ex("tset_noinc", 4'd2, 3'b010, 0, 0, 0, 0, 0);
    quick_short();
    drive(0, 0, 0); ex("tset_sec", 4'd2, 3'b001, 0, 0, 0, 0, 0);
    quick_short();
    drive(0, 0, 0); ex("tset_hour", 4'd2, 3'b100, 0, 0, 0, 0, 0);
    quick_short();
    drive(0, 0, 0); ex("tset_wrap", 4'd2, 3'b010, 0, 0, 0, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 0); ex("tset_commit", 4'd2, 3'b010, 0, 0, 1, 0, 0);
    drive(0, 0, 0); ex("tset_exit", 4'd0, 3'b000, 0, 0, 0, 0, 0);

    // Into DATE_SET, idle timeout
    quick_short(); quick_short(); quick_short();
    drive(1, 0, 0); ex("date_disp2", 4'd8, 3'b000, 0, 0, 0, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 0); ex("date_long", 4'd8, 3'b000, 0, 0, 0, 1, 0);
    drive(0, 0, 0); ex("dset_entry", 4'd10, 3'b010, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 19; i++) begin
      drive(0, 0, 0);
      if (i == 18) ex("dset_idle18", 4'd10, 3'b010, 0, 0, 0, 0, 0);
      if (i == 19) ex("dset_timeout", 4'd10, 3'b010, 0, 0, 0, 0, 1);
    end
    drive(0, 0, 0); ex("dset_abandoned", 4'd8, 3'b000, 0, 0, 0, 0, 0);

    // Again, but a short press lands on the timeout cycle
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 0); ex("date_long2", 4'd8, 3'b000, 0, 0, 0, 1, 0);
    drive(0, 0, 0); ex("dset_entry2", 4'd10, 3'b010, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 17; i++) drive(0, 0, 0);
    drive(1, 0, 0); ex("dset_c18_hi", 4'd10, 3'b010, 0, 0, 0, 0, 0);
    drive(0, 0, 0); ex("dset_press_wins", 4'd10, 3'b010, 0, 0, 0, 0, 0);
    drive(0, 0, 0); ex("dset_date_fld", 4'd10, 3'b001, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 19; i++) begin
      drive(0, 0, 0);
      if (i == 18) ex("dset_restart18", 4'd10, 3'b001, 0, 0, 0, 0, 0);
      if (i == 19) ex("dset_timeout2", 4'd10, 3'b001, 0, 0, 0, 0, 1);
    end
    drive(0, 0, 0); ex("dset_abandoned2", 4'd8, 3'b000, 0, 0, 0, 0, 0);

    // DATE -> TIME -> STW -> ALM, then ALM_SET fields and reset mid-session
    quick_short(); quick_short(); quick_short();
    drive(1, 0, 0); ex("alm_disp2", 4'd6, 3'b000, 0, 0, 0, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 0); ex("alm_long", 4'd6, 3'b000, 0, 0, 0, 1, 0);
    drive(0, 0, 0); ex("aset_min", 4'd7, 3'b010, 0, 0, 0, 0, 0);
    quick_short();
    drive(0, 0, 0); ex("aset_hour", 4'd7, 3'b100, 0, 0, 0, 0, 0);
    quick_short();
    drive(0, 0, 0); ex("aset_wrap", 4'd7, 3'b010, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    ae_m  = 2'b00;
    as_m  = 2'd0;
    #1;
    ex("async_reset", 4'd0, 3'b000, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ex("after_reset", 4'd0, 3'b000, 0, 0, 0, 0, 0);

    // Held switch in TIME_SET
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 0); ex("time_long2", 4'd0, 3'b000, 0, 0, 0, 1, 0);
    drive(0, 0, 0); ex("tset_entry2", 4'd2, 3'b010, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
`ifdef AUTO_REPEAT_EN
      se_exp = (k == 0) || (k == 8) || (k == 12) || (k == 16);
`else
      se_exp = 1'b1;
`endif
      drive(0, 0, 1); ex($sformatf("hold_k%0d", k), 4'd2, 3'b010, se_exp, 0, 0, 0, 0);
    end
    drive(0, 0, 0); ex("hold_release", 4'd2, 3'b010, 0, 0, 0, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 0); ex("tset_commit2", 4'd2, 3'b010, 0, 0, 1, 0, 0);
    drive(0, 0, 0); ex("tset_exit2", 4'd0, 3'b000, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
